// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbiter: RAM handshake states, word type, grant FSM states.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one single-port RAM between icache and dcache; dcache has priority with
// two-beat bursts, and a streak counter forces an icache grant to prevent starvation.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int BURST_LEN   = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              arb_err
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  arb_state_t    state, state_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [SW-1:0] streak, streak_nxt, streak_upd;
  logic          d_req, access;

  assign d_req  = dREN | dWEN;
  assign access = (ramstate == ACCESS);

  // Streak value at the end of a dcache grant: counts only while icache is kept waiting.
  assign streak_upd = !iREN ? '0 :
                      (streak == SW'(MAX_DSTREAK)) ? streak : streak + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      beat_cnt <= '0;
      streak   <= '0;
      arb_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      streak   <= streak_nxt;
      if (state != IDLE && ramstate == ERROR)
        arb_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_cnt;
    streak_nxt = streak;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    case (state)
      IDLE: begin
        if (d_req && !(iREN && streak == SW'(MAX_DSTREAK))) begin
          state_nxt = DGRANT;
          beat_nxt  = '0;
        end else if (iREN) begin
          state_nxt = IGRANT;
        end
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (access) begin
          iwait      = 1'b0;
          iload      = ramload;
          state_nxt  = IDLE;
          streak_nxt = '0;
        end
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_nxt  = IDLE;
          streak_nxt = streak_upd;
        end else if (access) begin
          dwait = 1'b0;
          if (!dWEN) dload = ramload;
          if (beat_cnt < BW'(BURST_LEN - 1)) begin
            beat_nxt = beat_cnt + 1'b1;
          end else begin
            state_nxt  = IDLE;
            streak_nxt = streak_upd;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: RAM responses driven per cycle, outputs checked with immediate assertions.
module tb_cache_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int total = 0;
  int bad   = 0;

  cache_mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later, well clear of the next edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_arb_err", arb_err, 0);
    cyc(); cyc();
    RST = 1'b0;

    // 1: icache read alone, ACCESS on the second granted cycle
    iREN = 1; iaddr = 32'h40; #1;
    chk("t1_idle_ramREN", ramREN, 0);
    chk("t1_idle_iwait", iwait, 1);
    cyc();
    ramstate = BUSY; ramload = 32'hBEEF; #1;
    chk("t1_g1_ramREN", ramREN, 1);
    chk("t1_g1_ramaddr", ramaddr, 32'h40);
    chk("t1_g1_iwait", iwait, 1);
    chk("t1_g1_iload", iload, 0);
    cyc();
    ramstate = ACCESS; ramload = 32'hDEAD; #1;
    chk("t1_g2_iwait", iwait, 0);
    chk("t1_g2_iload", iload, 32'hDEAD);
    chk("t1_g2_ramWEN", ramWEN, 0);
    chk("t1_g2_dwait", dwait, 1);
    cyc();
    iREN = 0; ramstate = FREE; #1;
    chk("t1_done_iwait", iwait, 1);
    chk("t1_done_ramREN", ramREN, 0);

    // 2: simultaneous requests, dcache wins with a two-beat burst, then icache
    iREN = 1; dREN = 1; daddr = 32'h80; #1;
    chk("t2_idle_dwait", dwait, 1);
    cyc();
    ramstate = ACCESS; ramload = 32'h1111; #1;
    chk("t2_b0_ramREN", ramREN, 1);
    chk("t2_b0_ramaddr", ramaddr, 32'h80);
    chk("t2_b0_dwait", dwait, 0);
    chk("t2_b0_dload", dload, 32'h1111);
    chk("t2_b0_iwait", iwait, 1);
    cyc();
    daddr = 32'h84; ramload = 32'h2222; #1;
    chk("t2_b1_ramaddr", ramaddr, 32'h84);
    chk("t2_b1_dwait", dwait, 0);
    chk("t2_b1_dload", dload, 32'h2222);
    cyc();
    dREN = 0; ramstate = FREE; #1;
    chk("t2_idle2_ramREN", ramREN, 0);
    cyc();
    ramstate = ACCESS; ramload = 32'h3333; #1;
    chk("t2_ig_ramaddr", ramaddr, 32'h40);
    chk("t2_ig_iwait", iwait, 0);
    chk("t2_ig_iload", iload, 32'h3333);
    cyc();
    iREN = 0; ramstate = FREE; #1;

    // 3: continuous dcache bursts with icache waiting -> forced icache grant after 4 bursts
    iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200; ramstate = ACCESS; ramload = 32'h55; #1;
    chk("t3_start_ramREN", ramREN, 0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("t3_burst%0d_beat0", b), ramaddr, 32'h200);
      chk($sformatf("t3_burst%0d_dwait0", b), dwait, 0);
      cyc();
      chk($sformatf("t3_burst%0d_beat1", b), ramaddr, 32'h200);
      cyc();
      chk($sformatf("t3_burst%0d_idle", b), ramREN, 0);
      cyc();
    end
    chk("t3_forced_ramaddr", ramaddr, 32'h100);
    chk("t3_forced_iwait", iwait, 0);
    chk("t3_forced_dwait", dwait, 1);
    cyc();
    chk("t3_after_idle", ramREN, 0);
    cyc();
    chk("t3_streak_reset_dgrant", ramaddr, 32'h200);
    cyc();
    dREN = 0; iREN = 0; ramstate = FREE; #1;
    chk("t3_abort_dwait", dwait, 1);
    cyc();
    #1;
    chk("t3_abort_idle", ramREN, 0);

    // 4: dcache write (dWEN wins over dREN)
    dWEN = 1; dREN = 1; daddr = 32'h3100; dstore = 32'h1234; cyc();
    ramstate = BUSY; #1;
    chk("t4_ramWEN", ramWEN, 1);
    chk("t4_ramREN", ramREN, 0);
    chk("t4_ramstore", ramstore, 32'h1234);
    chk("t4_ramaddr", ramaddr, 32'h3100);
    chk("t4_busy_dwait", dwait, 1);
    cyc();
    ramstate = ACCESS; ramload = 32'h9999; #1;
    chk("t4_acc_dwait", dwait, 0);
    chk("t4_acc_dload", dload, 0);
    cyc();
    dWEN = 0; dREN = 0; ramstate = FREE; #1;
    chk("t4_abort_dwait", dwait, 1);
    cyc();

    // 5: ERROR for three cycles mid beat, then ACCESS completes it
    dREN = 1; daddr = 32'h500; cyc();
    ramstate = ERROR; #1;
    chk("t5_err0_dwait", dwait, 1);
    chk("t5_err0_arb_err", arb_err, 0);
    for (int k = 1; k < 3; k++) begin
      cyc();
      chk($sformatf("t5_err%0d_dwait", k), dwait, 1);
      chk($sformatf("t5_err%0d_ramaddr", k), ramaddr, 32'h500);
      chk($sformatf("t5_err%0d_arb_err", k), arb_err, 1);
    end
    cyc();
    ramstate = ACCESS; ramload = 32'hCAFE; #1;
    chk("t5_acc_dwait", dwait, 0);
    chk("t5_acc_dload", dload, 32'hCAFE);
    chk("t5_acc_arb_err", arb_err, 1);
    cyc();
    dREN = 0; ramstate = FREE; cyc();

    // 6: reset asserted while icache grant is BUSY
    iREN = 1; iaddr = 32'h40; cyc();
    ramstate = BUSY; #1;
    chk("t6_grant_ramREN", ramREN, 1);
    #2 RST = 1'b1; #1;
    chk("t6_rst_ramREN", ramREN, 0);
    chk("t6_rst_ramaddr", ramaddr, 0);
    chk("t6_rst_iwait", iwait, 1);
    chk("t6_rst_arb_err", arb_err, 0);
    cyc();
    RST = 1'b0; #1;
    chk("t6_post_idle", ramREN, 0);
    cyc();
    chk("t6_post_regrant", ramREN, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
